// File: rtl/bus_watchdog.sv
// ---------------------------------------------------------------------------
// bus_watchdog
//
// 68000 bus-error watchdog. Every CPU bus cycle is timed from the point where
// the synchronised address strobe goes low. If no termination arrives in time,
// BERR is asserted and held until the CPU negates AS.
//   - DTACK-terminated cycles are timed in clk cycles (limit TIMEOUT).
//   - VPA (6800-style) cycles are timed in E-clock rising edges
//     (limit E_TIMEOUT).
//
// Optional feature macro: BERR_STATS_EN
//   When defined, adds a saturating fault counter, the time base of the last
//   fault, and a synchronous statistics clear.
//
// Parameters:
//   CNT_W     - width of the clk-cycle counter
//   TIMEOUT   - clk cycles allowed in a normal cycle (2 .. 2^CNT_W-1)
//   E_CNT_W   - width of the E-rise counter
//   E_TIMEOUT - E rises allowed in a VPA cycle (2 .. 2^E_CNT_W-1)
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   enable     in   watchdog enable; 0 stops timing (a pending fault completes)
//   as_n       in   CPU address strobe, asynchronous, active low
//   dtack_n    in   data transfer acknowledge, asynchronous, active low
//   vpa_n      in   valid peripheral address, asynchronous, active low
//   e          in   68000 E clock, asynchronous
//   stat_clr   in   (BERR_STATS_EN) clear fault statistics
//   fault_cnt  out  (BERR_STATS_EN) saturating fault count
//   fault_e    out  (BERR_STATS_EN) last fault happened while E-timing
//   berr_n     out  bus error to CPU, active low, registered
//   berr_pulse out  one-clk strobe on entering FAULT
// ---------------------------------------------------------------------------
module bus_watchdog #(
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 1024,
    parameter int E_CNT_W   = 6,
    parameter int E_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       as_n,
    input  logic       dtack_n,
    input  logic       vpa_n,
    input  logic       e,
`ifdef BERR_STATS_EN
    input  logic       stat_clr,
    output logic [7:0] fault_cnt,
    output logic       fault_e,
`endif
    output logic       berr_n,
    output logic       berr_pulse
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        EMODE = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_t;

    // Compare values are one below the limits: the FAULT decision is made on
    // the edge where the counter would otherwise reach the limit.
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [E_CNT_W-1:0] ECNT_LAST = E_CNT_W'(E_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [E_CNT_W-1:0] ECNT_ONE  = {{(E_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [E_CNT_W-1:0] ECNT_ZERO = {E_CNT_W{1'b0}};

    logic               as_meta_r, dtack_meta_r, vpa_meta_r, e_meta_r;
    logic               as_s, dtack_s, vpa_s, e_s, e_prev;
    logic               e_rise_s;
    state_t             state_r, next_state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [E_CNT_W-1:0] ecnt_r, ecnt_nxt_s;
    logic               fault_entry_s;

    // Two-flop synchronisers for the asynchronous bus pins plus E edge history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            as_meta_r    <= 1'b1;
            as_s         <= 1'b1;
            dtack_meta_r <= 1'b1;
            dtack_s      <= 1'b1;
            vpa_meta_r   <= 1'b1;
            vpa_s        <= 1'b1;
            e_meta_r     <= 1'b0;
            e_s          <= 1'b0;
            e_prev       <= 1'b0;
        end else begin
            as_meta_r    <= as_n;
            as_s         <= as_meta_r;
            dtack_meta_r <= dtack_n;
            dtack_s      <= dtack_meta_r;
            vpa_meta_r   <= vpa_n;
            vpa_s        <= vpa_meta_r;
            e_meta_r     <= e;
            e_s          <= e_meta_r;
            e_prev       <= e_s;
        end
    end

    assign e_rise_s      = e_s & ~e_prev;
    assign fault_entry_s = (next_state_s == FAULT) && (state_r != FAULT);

    // Next-state and counter decode; AS negation always wins over timeouts
    always_comb begin
        next_state_s = state_r;
        cnt_nxt_s    = cnt_r;
        ecnt_nxt_s   = ecnt_r;
        case (state_r)
            IDLE: begin
                cnt_nxt_s  = CNT_ZERO;
                ecnt_nxt_s = ECNT_ZERO;
                if (!as_s && enable) begin
                    next_state_s = ARMED;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ARMED: begin
                if (!enable || as_s) begin
                    next_state_s = IDLE;
                    cnt_nxt_s    = CNT_ZERO;
                    ecnt_nxt_s   = ECNT_ZERO;
                end else if (!dtack_s) begin
                    next_state_s = DONE;
                end else if (!vpa_s) begin
                    next_state_s = EMODE;
                    ecnt_nxt_s   = ECNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    next_state_s = FAULT;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            EMODE: begin
                // clk counter frozen; DTACK is not a valid termination here
                if (!enable || as_s) begin
                    next_state_s = IDLE;
                    cnt_nxt_s    = CNT_ZERO;
                    ecnt_nxt_s   = ECNT_ZERO;
                end else if (e_rise_s) begin
                    if (ecnt_r == ECNT_LAST) begin
                        next_state_s = FAULT;
                    end else begin
                        ecnt_nxt_s = ecnt_r + ECNT_ONE;
                    end
                end else begin
                    next_state_s = EMODE;
                end
            end
            DONE: begin
                if (!enable || as_s) begin
                    next_state_s = IDLE;
                    cnt_nxt_s    = CNT_ZERO;
                    ecnt_nxt_s   = ECNT_ZERO;
                end else begin
                    next_state_s = DONE;
                end
            end
            FAULT: begin
                // enable is ignored: BERR must stay asserted until AS negates
                if (as_s) begin
                    next_state_s = IDLE;
                    cnt_nxt_s    = CNT_ZERO;
                    ecnt_nxt_s   = ECNT_ZERO;
                end else begin
                    next_state_s = FAULT;
                end
            end
            default: begin
                next_state_s = IDLE;
                cnt_nxt_s    = CNT_ZERO;
                ecnt_nxt_s   = ECNT_ZERO;
            end
        endcase
    end

    // State, counters and registered bus-error outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            ecnt_r     <= ECNT_ZERO;
            berr_n     <= 1'b1;
            berr_pulse <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            cnt_r      <= cnt_nxt_s;
            ecnt_r     <= ecnt_nxt_s;
            berr_n     <= (next_state_s != FAULT);
            berr_pulse <= fault_entry_s;
        end
    end

`ifdef BERR_STATS_EN
    // Fault statistics: saturating count and time base of the latest fault
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_cnt <= 8'd0;
            fault_e   <= 1'b0;
        end else if (stat_clr) begin
            fault_cnt <= 8'd0;
            fault_e   <= 1'b0;
        end else if (fault_entry_s) begin
            fault_cnt <= (fault_cnt == 8'd255) ? 8'd255 : fault_cnt + 8'd1;
            fault_e   <= (state_r == EMODE);
        end else begin
            fault_cnt <= fault_cnt;
            fault_e   <= fault_e;
        end
    end
`endif

endmodule

// File: tb/tb_bus_watchdog.sv
// ---------------------------------------------------------------------------
// tb_bus_watchdog
//
// Self-checking bench for bus_watchdog with TIMEOUT=16 and E_TIMEOUT=4.
// A bus-cycle reference model (pin history + cycle bookkeeping) is stepped
// on every clock edge and compared against berr_n / berr_pulse (and the
// statistics outputs when BERR_STATS_EN is defined). On top of that, a table
// of scenarios carries hand-derived expected fault edges, and a few
// hand-written sequences cover enable, reset and back-to-back corners.
// ---------------------------------------------------------------------------
module tb_bus_watchdog;

    localparam int CNT_W     = 16;
    localparam int TIMEOUT   = 16;
    localparam int E_CNT_W   = 6;
    localparam int E_TIMEOUT = 4;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic enable  = 1'b1;
    logic as_n    = 1'b1;
    logic dtack_n = 1'b1;
    logic vpa_n   = 1'b1;
    logic e       = 1'b0;
    logic berr_n;
    logic berr_pulse;
`ifdef BERR_STATS_EN
    logic       stat_clr = 1'b0;
    logic [7:0] fault_cnt;
    logic       fault_e;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bus_watchdog #(
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT),
        .E_CNT_W  (E_CNT_W),
        .E_TIMEOUT(E_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .as_n      (as_n),
        .dtack_n   (dtack_n),
        .vpa_n     (vpa_n),
        .e         (e),
`ifdef BERR_STATS_EN
        .stat_clr  (stat_clr),
        .fault_cnt (fault_cnt),
        .fault_e   (fault_e),
`endif
        .berr_n    (berr_n),
        .berr_pulse(berr_pulse)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Pin history, newest in bit 0: bit1 is what the core sees as the
    // synchronised value, bit2 is one edge older (E edge detection).
    bit [2:0] h_as, h_dt, h_vpa, h_e;
    bit m_busy, m_eclk, m_acked, m_fault;
    int m_elapsed, m_rises;
    bit m_berr_n = 1'b1;
    bit m_pulse  = 1'b0;
    int m_fcnt   = 0;
    bit m_fe     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic raise_fault(input bit from_e);
        m_fault  = 1'b1;
        m_busy   = 1'b0;
        m_berr_n = 1'b0;
        m_pulse  = 1'b1;
        m_fcnt   = (m_fcnt >= 255) ? 255 : m_fcnt + 1;
        m_fe     = from_e;
    endtask

    task automatic model_step();
        bit a, d, v, rise;
        if (!rst_n) begin
            h_as = 3'b111; h_dt = 3'b111; h_vpa = 3'b111; h_e = 3'b000;
            m_busy = 1'b0; m_eclk = 1'b0; m_acked = 1'b0; m_fault = 1'b0;
            m_elapsed = 0; m_rises = 0;
            m_berr_n = 1'b1; m_pulse = 1'b0; m_fcnt = 0; m_fe = 1'b0;
            return;
        end
        a    = h_as[1];
        d    = h_dt[1];
        v    = h_vpa[1];
        rise = h_e[1] && !h_e[2];
        m_pulse = 1'b0;
        if (m_fault) begin
            if (a) begin
                m_fault  = 1'b0;
                m_berr_n = 1'b1;
            end
        end else if (!m_busy) begin
            if (!a && enable) begin
                m_busy = 1'b1; m_eclk = 1'b0; m_acked = 1'b0;
                m_elapsed = 0; m_rises = 0;
            end
        end else if (!enable || a) begin
            m_busy = 1'b0;
        end else if (!m_acked) begin
            if (m_eclk) begin
                if (rise) begin
                    m_rises++;
                    if (m_rises == E_TIMEOUT) raise_fault(1'b1);
                end
            end else if (!d) begin
                m_acked = 1'b1;
            end else if (!v) begin
                m_eclk  = 1'b1;
                m_rises = 0;
            end else begin
                m_elapsed++;
                if (m_elapsed == TIMEOUT) raise_fault(1'b0);
            end
        end
`ifdef BERR_STATS_EN
        if (stat_clr) begin
            m_fcnt = 0;
            m_fe   = 1'b0;
        end
`endif
        h_as  = {h_as[1:0], as_n};
        h_dt  = {h_dt[1:0], dtack_n};
        h_vpa = {h_vpa[1:0], vpa_n};
        h_e   = {h_e[1:0], e};
    endtask

    // One clock edge: step the model, then compare 1 time unit later
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("berr_n", berr_n, m_berr_n);
        check("berr_pulse", berr_pulse, m_pulse);
`ifdef BERR_STATS_EN
        check("fault_cnt", fault_cnt, m_fcnt);
        check("fault_e", fault_e, m_fe);
`endif
    endtask

    task automatic idle_pins();
        as_n = 1'b1; dtack_n = 1'b1; vpa_n = 1'b1; e = 1'b0; enable = 1'b1;
    endtask

    task automatic gap(input int n);
        idle_pins();
        for (int k = 0; k < n; k++) tick();
    endtask

    // ---------------- scenario table ----------------
    // Edges are numbered from 1 = first edge that sees as_n low.
    typedef struct {
        int as_hold;   // as_n low for edges 1..as_hold
        int dtack_at;  // dtack_n low from edge dtack_at+1 (-1: never)
        int vpa_at;    // vpa_n low from edge vpa_at+1 (-1: never)
        bit e_on;      // E with period 10 clk, first pin rise at edge 6
        int en_off;    // enable low from edge en_off+1 (0: never)
        int en_on;     // enable high again from edge en_on (0: not in scenario)
        int exp_fall;  // edge where berr_n must fall (0: no fault)
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    task automatic drive_vec(input vec_t v, input int m);
        bit in_cycle;
        in_cycle = (m <= v.as_hold);
        as_n    = in_cycle ? 1'b0 : 1'b1;
        dtack_n = (in_cycle && v.dtack_at >= 0 && m > v.dtack_at) ? 1'b0 : 1'b1;
        vpa_n   = (in_cycle && v.vpa_at >= 0 && m > v.vpa_at) ? 1'b0 : 1'b1;
        e       = (v.e_on && ((m - 1) % 10) >= 5) ? 1'b1 : 1'b0;
        enable  = (v.en_off > 0 && m > v.en_off && (v.en_on == 0 || m < v.en_on)) ? 1'b0 : 1'b1;
    endtask

    task automatic run_vec(input int i);
        int fall     = 0;
        int rise     = 0;
        int pulses   = 0;
        int pulse_at = 0;
        for (int m = 1; m <= vecs[i].as_hold + 8; m++) begin
            drive_vec(vecs[i], m);
            tick();
            if (fall == 0 && berr_n === 1'b0) fall = m;
            if (fall != 0 && rise == 0 && berr_n === 1'b1) rise = m;
            if (berr_pulse === 1'b1) begin
                pulses++;
                pulse_at = m;
            end
        end
        gap(10);
        check($sformatf("vec%0d fall_edge", i), fall, vecs[i].exp_fall);
        check($sformatf("vec%0d pulse_count", i), pulses, (vecs[i].exp_fall != 0) ? 1 : 0);
        if (vecs[i].exp_fall != 0) begin
            check($sformatf("vec%0d rise_edge", i), rise, vecs[i].as_hold + 3);
            check($sformatf("vec%0d pulse_edge", i), pulse_at, vecs[i].exp_fall);
        end
    endtask

    // Hold AS low until BERR falls (bounded); returns the fall edge or 0
    task automatic wait_fault(output int fall_edge);
        fall_edge = 0;
        as_n = 1'b0;
        for (int m = 1; m <= 40 && fall_edge == 0; m++) begin
            tick();
            if (berr_n === 1'b0) fall_edge = m;
        end
    endtask

    // ---------------- random phase ----------------
    task automatic run_random(input int cycles);
        int e_left = 4;
        for (int k = 0; k < cycles; k++) begin
            if (as_n) begin
                if ($urandom_range(0, 9) == 0) as_n = 1'b0;
            end else begin
                if ($urandom_range(0, 29) == 0) as_n = 1'b1;
            end
            if (as_n) begin
                dtack_n = 1'b1;
                vpa_n   = 1'b1;
            end else begin
                if ($urandom_range(0, 39) == 0) dtack_n = 1'b0;
                if ($urandom_range(0, 29) == 0) vpa_n = 1'b0;
            end
            e_left--;
            if (e_left == 0) begin
                e      = ~e;
                e_left = $urandom_range(1, 6);
            end
            if (!enable) enable = ($urandom_range(0, 4) == 0);
            else         enable = ($urandom_range(0, 149) != 0);
            rst_n = ($urandom_range(0, 499) != 0);
`ifdef BERR_STATS_EN
            stat_clr = ($urandom_range(0, 199) == 0);
`endif
            tick();
        end
        rst_n = 1'b1;
`ifdef BERR_STATS_EN
        stat_clr = 1'b0;
`endif
    endtask

    initial begin
        int fe;
        int rise_cnt;

        vecs[0]  = '{40, -1, -1, 1'b0,  0,  0, 19}; // plain timeout
        vecs[1]  = '{100, 5, -1, 1'b0,  0,  0,  0}; // DTACK, AS held long
        vecs[2]  = '{40, 16, -1, 1'b0,  0,  0,  0}; // DTACK on the timeout edge
        vecs[3]  = '{40, 17, -1, 1'b0,  0,  0, 19}; // DTACK one edge too late
        vecs[4]  = '{16, -1, -1, 1'b0,  0,  0,  0}; // AS ends on the timeout edge
        vecs[5]  = '{17, -1, -1, 1'b0,  0,  0, 19}; // AS ends one edge too late
        vecs[6]  = '{40, -1,  0, 1'b1,  0,  0, 38}; // E timeout, 4th rise
        vecs[7]  = '{32, -1,  0, 1'b1,  0,  0,  0}; // AS negated after 3rd rise
        vecs[8]  = '{35, -1,  0, 1'b1,  0,  0,  0}; // AS negation meets 4th rise
        vecs[9]  = '{36, -1,  0, 1'b1,  0,  0, 38}; // AS negation one edge late
        vecs[10] = '{40, 10,  0, 1'b1,  0,  0, 38}; // DTACK ignored in E mode
        vecs[11] = '{40,  0,  0, 1'b1,  0,  0,  0}; // DTACK beats VPA
        vecs[12] = '{100, -1, 0, 1'b0,  0,  0,  0}; // VPA, no E: clk count frozen
        vecs[13] = '{60, -1, 10, 1'b1,  0,  0, 48}; // late VPA
        vecs[14] = '{40, -1, -1, 1'b0, 11,  0,  0}; // enable dropped at cnt=8
        vecs[15] = '{60, -1, -1, 1'b0, 11, 21, 37}; // enable re-asserted mid-cycle

        // reset state
        rst_n = 1'b0;
        idle_pins();
        tick();
        tick();
        check("reset berr_n", berr_n, 1'b1);
        check("reset berr_pulse", berr_pulse, 1'b0);
        rst_n = 1'b1;
        gap(5);

        for (int i = 0; i < NV; i++) run_vec(i);

        // enable dropped while in FAULT: BERR holds until AS negates
        wait_fault(fe);
        check("en_drop fault_edge", fe, 19);
        enable = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("en_drop berr_held", berr_n, 1'b0);
        as_n = 1'b1;
        rise_cnt = 0;
        for (int k = 1; k <= 10 && rise_cnt == 0; k++) begin
            tick();
            if (berr_n === 1'b1) rise_cnt = k;
        end
        check("en_drop rise_after_as", rise_cnt, 3);
        gap(10);

        // reset in the middle of a FAULT
        wait_fault(fe);
        check("rst_mid fault_edge", fe, 19);
        rst_n = 1'b0;
        as_n  = 1'b1;
        tick();
        check("rst_mid berr_n", berr_n, 1'b1);
        check("rst_mid berr_pulse", berr_pulse, 1'b0);
        rst_n = 1'b1;
        gap(10);

        // back-to-back: AS high for one clk, next cycle arms afresh
        fe = 0;
        for (int m = 1; m <= 40; m++) begin
            as_n = (m == 11) ? 1'b1 : 1'b0;
            tick();
            if (fe == 0 && berr_n === 1'b0) fe = m;
        end
        check("b2b fall_edge", fe, 30);
        gap(10);

`ifdef BERR_STATS_EN
        for (int f = 0; f < 300; f++) begin
            for (int m = 1; m <= 20; m++) begin
                as_n = 1'b0;
                tick();
            end
            gap(5);
        end
        check("stats saturate", fault_cnt, 8'd255);
        check("stats clk fault_e", fault_e, 1'b0);
        run_vec(6);
        check("stats e fault_e", fault_e, 1'b1);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("stats clr cnt", fault_cnt, 8'd0);
        check("stats clr fault_e", fault_e, 1'b0);
        gap(5);
`endif

        run_random(4000);
        gap(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_watchdog.md
Name: bus_watchdog

Overview:
- Parametrised 68000 bus-error watchdog. Times every CPU bus cycle from AS assertion and drives BERR when no termination arrives in time.
- Two time bases: normal cycles (DTACK-terminated) are timed in clk cycles. 6800-style cycles (VPA-terminated) are timed in E-clock periods with a separate limit.
- Sits beside the CPU glue logic. berr_n feeds the CPU BERR pin through the existing open-drain pad.

Parameters:
- CNT_W, 16, width of the clk-cycle timeout counter.
- TIMEOUT, 1024, clk cycles allowed from AS sampled low to termination. Legal range 2 to 2^CNT_W-1.
- E_CNT_W, 6, width of the E-period counter.
- E_TIMEOUT, 32, E rising edges allowed in a VPA cycle. Legal range 2 to 2^E_CNT_W-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  watchdog enable; 0 disables timing
- as_n  in  1  CPU address strobe, asynchronous, active low
- dtack_n  in  1  data transfer acknowledge, asynchronous, active low
- vpa_n  in  1  valid peripheral address, asynchronous, active low
- e  in  1  68000 E clock, asynchronous
- berr_n  out  1  bus error to CPU, active low, registered
- berr_pulse  out  1  one-clk strobe on entering FAULT
- fault_cnt  out  8  (BERR_STATS_EN only) saturating fault count
- fault_e  out  1  (BERR_STATS_EN only) 1 if last fault was in E mode
- stat_clr  in  1  (BERR_STATS_EN only) synchronous clear of statistics

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-low (rst_n).
- Synchronisers: as_n, dtack_n, vpa_n and e each pass through a 2-flop synchroniser (as_s, dtack_s, vpa_s, e_s), so pin-to-internal latency is 2 clk. e_prev is registered from e_s; an E rise is e_s=1 and e_prev=0.
- Reset values, applied on the first clk edge with rst_n=0 regardless of state:
  - state=IDLE, cnt=0, ecnt=0.
  - berr_n=1, berr_pulse=0.
  - Synchroniser flops =1, except e flops =0.
  - fault_cnt=0, fault_e=0.
- IDLE:
  - cnt=0, ecnt=0.
  - Go to ARMED when as_s=0 and enable=1.
- ARMED (clk timing):
  - cnt increments each clk.
  - Exit priority, highest first:
    1. as_s=1 -> IDLE (cycle ended).
    2. dtack_s=0 -> DONE.
    3. vpa_s=0 -> EMODE (ecnt=0).
    4. cnt=TIMEOUT-1 -> FAULT.
  - Termination wins over timeout when both occur in the same cycle.
- EMODE (E timing):
  - cnt frozen; ecnt increments on each E rise.
  - as_s=1 -> IDLE (has priority).
  - Else E rise with ecnt=E_TIMEOUT-1 -> FAULT.
  - dtack_s is ignored in EMODE.
- DONE: hold until as_s=1 -> IDLE. No timing in DONE.
- FAULT:
  - berr_n=0 from the entering edge.
  - berr_pulse=1 for exactly the entering cycle.
  - Hold berr_n=0 until as_s=1. On that edge berr_n=1 and state goes to IDLE, so BERR never negates before AS.
- Latency: with as_n held low and no termination, berr_n falls exactly TIMEOUT+1 clk edges after the edge where as_s is first sampled low (1 edge IDLE->ARMED, then TIMEOUT counts). That is TIMEOUT+3 edges from the pin.
- enable:
  - enable=0 in ARMED, EMODE or DONE forces IDLE on the next edge.
  - enable=0 in FAULT has no effect; the current fault completes.
  - enable re-asserted mid-cycle (as_s already 0) starts timing from that edge.
- Back-to-back cycles: AS negated for a single synchronised clk returns to IDLE, and the next AS arms afresh with cnt=0.
- Counters: cnt never wraps, because the FAULT compare occurs before overflow given legal parameters. Illegal parameters are a bench-time assertion, not RTL behaviour.

Optional Feature:
- Macro BERR_STATS_EN.
- Defined:
  - fault_cnt, fault_e and stat_clr ports exist.
  - On each FAULT entry, fault_cnt increments and saturates at 255.
  - On each FAULT entry, fault_e is set to 1 if entered from EMODE, else 0.
  - stat_clr=1 zeroes both on the next edge. Clear wins over a simultaneous fault increment.
- Undefined: those ports and registers are absent; all other behaviour is identical.

Test Plan (TIMEOUT=16, E_TIMEOUT=4, enable=1 unless stated):
- as_n low held 40 clk, dtack_n high, vpa_n high -> berr_n falls 19 edges after as_n falls; berr_pulse high 1 cycle; berr_n rises 3 edges after as_n rises.
- as_n low, dtack_n low 5 clk later -> berr_n stays 1 for the entire cycle, even with AS held 100 clk.
- dtack_s and cnt=15 on the same edge -> DONE, no berr_pulse.
- as_n low, vpa_n low, e period 10 clk -> berr_n falls on the 4th synchronised E rise. Repeat with as_n negated after the 3rd rise -> no fault.
- Timeout in progress, then enable dropped at cnt=8 -> IDLE, no fault. Drop enable while in FAULT -> berr_n held until as_n negates.
- rst_n low mid-FAULT -> berr_n=1 after 1 edge. With BERR_STATS_EN: 300 faults -> fault_cnt=255; stat_clr -> 0.
